// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, stall hold, flush
// squash and a saturating count of inserted bubbles.
module id_ex_reg #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_write_reg,
    input  logic              id_rs_valid,
    input  logic              id_rt_valid,
    input  logic              id_write_reg_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [3:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [REG_W-1:0]  RsIdEx,
    output logic [REG_W-1:0]  RtIdEx,
    output logic [REG_W-1:0]  writeRegIdEx,
    output logic              RsValidIdEx,
    output logic              RtValidIdEx,
    output logic              writeRegValidIdEx,
    output logic              RegWriteIdEx,
    output logic              MemReadIdEx,
    output logic              MemWriteIdEx,
    output logic [3:0]        aluOpIdEx,
    output logic [DATA_W-1:0] rsDataIdEx,
    output logic [DATA_W-1:0] rtDataIdEx,
    output logic [DATA_W-1:0] immIdEx,
    output logic [DATA_W-1:0] pcIdEx,
    output logic              id_hold,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  wr;
        logic              rs_valid;
        logic              rt_valid;
        logic              wr_valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [3:0]        alu_op;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
    } stage_t;

    stage_t            stage_q, stage_d, id_stage;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic              rs_match, rt_match, hazard, load_bubble;

    // Side-effecting controls are gated so an empty slot can never write.
    always_comb begin
        id_stage           = '0;
        id_stage.valid     = id_valid;
        id_stage.rs        = id_rs;
        id_stage.rt        = id_rt;
        id_stage.wr        = id_write_reg;
        id_stage.rs_valid  = id_rs_valid;
        id_stage.rt_valid  = id_rt_valid;
        id_stage.wr_valid  = id_write_reg_valid;
        id_stage.reg_write = id_valid & id_reg_write;
        id_stage.mem_read  = id_valid & id_mem_read;
        id_stage.mem_write = id_valid & id_mem_write;
        id_stage.alu_op    = id_alu_op;
        id_stage.rs_data   = id_rs_data;
        id_stage.rt_data   = id_rt_data;
        id_stage.imm       = id_imm;
        id_stage.pc        = id_pc;
    end

    assign rs_match = id_rs_valid & (id_rs == stage_q.wr);
    assign rt_match = id_rt_valid & (id_rt == stage_q.wr);
    assign hazard   = stage_q.valid & stage_q.mem_read & stage_q.wr_valid
                    & id_valid & (rs_match | rt_match);

    // Load data only becomes forwardable from MEM/WB, so a dependent
    // instruction waits one cycle behind a bubble.
    assign id_hold = ~rst & ~flush & (ex_stall | hazard);

    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        load_bubble  = 1'b0;
        if (flush) begin
            stage_d     = '0;
            load_bubble = 1'b1;
        end else if (ex_stall) begin
            stage_d = stage_q;
        end else if (hazard) begin
            stage_d     = '0;
            load_bubble = 1'b1;
        end else begin
            stage_d = id_stage;
        end
        if (load_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid          = stage_q.valid;
    assign RsIdEx            = stage_q.rs;
    assign RtIdEx            = stage_q.rt;
    assign writeRegIdEx      = stage_q.wr;
    assign RsValidIdEx       = stage_q.rs_valid;
    assign RtValidIdEx       = stage_q.rt_valid;
    assign writeRegValidIdEx = stage_q.wr_valid;
    assign RegWriteIdEx      = stage_q.reg_write;
    assign MemReadIdEx       = stage_q.mem_read;
    assign MemWriteIdEx      = stage_q.mem_write;
    assign aluOpIdEx         = stage_q.alu_op;
    assign rsDataIdEx        = stage_q.rs_data;
    assign rtDataIdEx        = stage_q.rt_data;
    assign immIdEx           = stage_q.imm;
    assign pcIdEx            = stage_q.pc;
    assign bubble_cnt        = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized, self-checking bench for id_ex_reg against a transaction-level
// model of what the EX slot should hold after each clock edge.
module tb_id_ex_reg;

    typedef struct packed {
        logic        v;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  wr;
        logic        rsv;
        logic        rtv;
        logic        wrv;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [3:0]  op;
        logic [15:0] rsd;
        logic [15:0] rtd;
        logic [15:0] imm;
        logic [15:0] pc;
    } slot_t;

    logic        clk, rst, ex_stall, flush;
    slot_t       din;
    logic        ex_valid, RsValidIdEx, RtValidIdEx, writeRegValidIdEx;
    logic        RegWriteIdEx, MemReadIdEx, MemWriteIdEx, id_hold;
    logic [2:0]  RsIdEx, RtIdEx, writeRegIdEx;
    logic [3:0]  aluOpIdEx;
    logic [15:0] rsDataIdEx, rtDataIdEx, immIdEx, pcIdEx;
    logic [7:0]  bubble_cnt;

    slot_t m;          // expected EX slot
    int    mcnt;       // expected bubble count
    int    checks = 0;
    int    passed = 0;

    id_ex_reg #(.DATA_W(16), .REG_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .id_valid(din.v),
        .id_rs(din.rs), .id_rt(din.rt), .id_write_reg(din.wr),
        .id_rs_valid(din.rsv), .id_rt_valid(din.rtv), .id_write_reg_valid(din.wrv),
        .id_reg_write(din.rw), .id_mem_read(din.mr), .id_mem_write(din.mw),
        .id_alu_op(din.op), .id_rs_data(din.rsd), .id_rt_data(din.rtd),
        .id_imm(din.imm), .id_pc(din.pc),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .RsIdEx(RsIdEx), .RtIdEx(RtIdEx), .writeRegIdEx(writeRegIdEx),
        .RsValidIdEx(RsValidIdEx), .RtValidIdEx(RtValidIdEx),
        .writeRegValidIdEx(writeRegValidIdEx),
        .RegWriteIdEx(RegWriteIdEx), .MemReadIdEx(MemReadIdEx), .MemWriteIdEx(MemWriteIdEx),
        .aluOpIdEx(aluOpIdEx), .rsDataIdEx(rsDataIdEx), .rtDataIdEx(rtDataIdEx),
        .immIdEx(immIdEx), .pcIdEx(pcIdEx), .id_hold(id_hold), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic slot_t obs();
        slot_t o;
        o = {ex_valid, RsIdEx, RtIdEx, writeRegIdEx, RsValidIdEx, RtValidIdEx,
             writeRegValidIdEx, RegWriteIdEx, MemReadIdEx, MemWriteIdEx, aluOpIdEx,
             rsDataIdEx, rtDataIdEx, immIdEx, pcIdEx};
        return o;
    endfunction

    function automatic slot_t rand_slot();
        slot_t s;
        s.v   = ($urandom_range(0, 3) != 0);
        s.rs  = 3'($urandom_range(0, 3));
        s.rt  = 3'($urandom_range(0, 3));
        s.wr  = 3'($urandom_range(0, 3));
        s.rsv = 1'($urandom);
        s.rtv = 1'($urandom);
        s.wrv = 1'($urandom);
        s.rw  = 1'($urandom);
        s.mr  = 1'($urandom);
        s.mw  = 1'($urandom);
        s.op  = 4'($urandom);
        s.rsd = 16'($urandom);
        s.rtd = 16'($urandom);
        s.imm = 16'($urandom);
        s.pc  = 16'($urandom);
        return s;
    endfunction

    // A load in EX blocks an ID instruction that reads its destination.
    function automatic bit model_hazard();
        return m.v && m.mr && m.wrv && din.v &&
               ((din.rsv && din.rs == m.wr) || (din.rtv && din.rt == m.wr));
    endfunction

    function automatic bit model_hold();
        return !flush && (ex_stall || model_hazard());
    endfunction

    // One clock edge; model advances with the same inputs the DUT sees.
    task automatic tick();
        slot_t nx;
        bit    bub;
        bub = 0;
        nx  = m;
        if (flush) begin
            nx = '0; bub = 1;
        end else if (ex_stall) begin
            nx = m;
        end else if (model_hazard()) begin
            nx = '0; bub = 1;
        end else begin
            nx = din;
            if (!din.v) begin nx.rw = 0; nx.mr = 0; nx.mw = 0; end
        end
        @(posedge clk);
        m = nx;
        if (bub && mcnt < 255) mcnt++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_stall = 0; flush = 0;
        din = rand_slot();
        #1;
        checks++;
        if (obs() !== '0 || bubble_cnt !== 8'h00 || id_hold !== 1'b0)
            $display("FAIL reset_initial: slot=%h cnt=%h hold=%b required all 0", obs(), bubble_cnt, id_hold);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        m = '0; mcnt = 0;
        // Load something, then reset mid-stall without a clock edge.
        din = rand_slot(); din.v = 1;
        tick();
        din.v = 0;
        flush = 1; tick(); flush = 0;
        din = rand_slot(); din.v = 1; tick();
        ex_stall = 1; #1;
        checks++;
        if (id_hold !== 1'b1) $display("FAIL stall_hold_pre_reset: hold=%b required 1", id_hold);
        else passed++;
        #2 rst = 1'b1; #1;
        checks++;
        if (obs() !== '0 || bubble_cnt !== 8'h00 || id_hold !== 1'b0)
            $display("FAIL reset_mid_stall: slot=%h cnt=%h hold=%b required all 0", obs(), bubble_cnt, id_hold);
        else passed++;
        @(negedge clk);
        rst = 1'b0; ex_stall = 0;
        m = '0; mcnt = 0;
        $display("reset: async clear checked");
    endtask

    task automatic test_pass_through();
        slot_t exp_s;
        din = rand_slot();
        din.v = 1; din.rs = 3; din.rt = 5; din.rw = 1; din.rsd = 16'h1234;
        #1;
        checks++;
        if (id_hold !== 1'b0) $display("FAIL pass_hold: hold=%b required 0", id_hold);
        else passed++;
        exp_s = din;
        tick();
        checks++;
        if (RsIdEx !== 3'd3 || RtIdEx !== 3'd5 || RegWriteIdEx !== 1'b1 ||
            rsDataIdEx !== 16'h1234 || ex_valid !== 1'b1 || id_hold !== 1'b0)
            $display("FAIL pass_fields: rs=%0d rt=%0d rw=%b rsd=%h v=%b hold=%b required 3 5 1 1234 1 0",
                     RsIdEx, RtIdEx, RegWriteIdEx, rsDataIdEx, ex_valid, id_hold);
        else passed++;
        checks++;
        if (obs() !== exp_s) $display("FAIL pass_slot: got %h required %h", obs(), exp_s);
        else passed++;
        // Invalid slot must not carry write-side controls.
        din = rand_slot(); din.v = 0; din.rw = 1; din.mr = 1; din.mw = 1;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || RegWriteIdEx !== 1'b0 || MemReadIdEx !== 1'b0 || MemWriteIdEx !== 1'b0)
            $display("FAIL invalid_gating: v=%b rw=%b mr=%b mw=%b required 0 0 0 0",
                     ex_valid, RegWriteIdEx, MemReadIdEx, MemWriteIdEx);
        else passed++;
        $display("pass_through: fields and invalid gating checked");
    endtask

    task automatic load_r2();
        din = rand_slot();
        din.v = 1; din.mr = 1; din.rw = 1; din.wr = 2; din.wrv = 1;
        din.rsv = 0; din.rtv = 0;
        tick();
    endtask

    task automatic test_load_use();
        int cnt0;
        load_r2();
        din = rand_slot();
        din.v = 1; din.rs = 2; din.rsv = 1; din.rt = 7; din.rtv = 0;
        #1;
        checks++;
        if (id_hold !== 1'b1) $display("FAIL loaduse_hold: hold=%b required 1", id_hold);
        else passed++;
        cnt0 = mcnt;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || RegWriteIdEx !== 1'b0 || bubble_cnt !== 8'(cnt0 + 1))
            $display("FAIL loaduse_bubble: v=%b rw=%b cnt=%0d required 0 0 %0d",
                     ex_valid, RegWriteIdEx, bubble_cnt, cnt0 + 1);
        else passed++;
        checks++;
        if (id_hold !== 1'b0) $display("FAIL loaduse_release: hold=%b required 0", id_hold);
        else passed++;
        tick();
        checks++;
        if (RsIdEx !== 3'd2 || ex_valid !== 1'b1 || obs() !== m)
            $display("FAIL loaduse_advance: rs=%0d v=%b slot=%h required rs=2 v=1 slot=%h",
                     RsIdEx, ex_valid, obs(), m);
        else passed++;
        $display("load_use: hold, bubble and advance checked");
    endtask

    task automatic test_no_false_hazard();
        int cnt0;
        load_r2();
        din = rand_slot(); din.v = 1; din.rs = 2; din.rsv = 0; din.rt = 2; din.rtv = 0;
        #1;
        checks++;
        if (id_hold !== 1'b0) $display("FAIL nohaz_rsvalid: hold=%b required 0", id_hold);
        else passed++;
        tick();
        // Load whose destination index is not actually written.
        din = rand_slot(); din.v = 1; din.mr = 1; din.wr = 2; din.wrv = 0;
        tick();
        din = rand_slot(); din.v = 1; din.rs = 2; din.rsv = 1;
        cnt0 = mcnt;
        #1;
        checks++;
        if (id_hold !== 1'b0) $display("FAIL nohaz_wrvalid: hold=%b required 0", id_hold);
        else passed++;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || bubble_cnt !== 8'(cnt0))
            $display("FAIL nohaz_nobubble: v=%b cnt=%0d required 1 %0d", ex_valid, bubble_cnt, cnt0);
        else passed++;
        $display("no_false_hazard: unused indices ignored");
    endtask

    task automatic test_flush_priority();
        int cnt0;
        load_r2();
        din = rand_slot(); din.v = 1; din.rs = 2; din.rsv = 1;
        ex_stall = 1; flush = 1;
        #1;
        checks++;
        if (id_hold !== 1'b0) $display("FAIL flush_hold: hold=%b required 0", id_hold);
        else passed++;
        cnt0 = mcnt;
        tick();
        ex_stall = 0; flush = 0;
        checks++;
        if (ex_valid !== 1'b0 || MemReadIdEx !== 1'b0 || bubble_cnt !== 8'(cnt0 + 1))
            $display("FAIL flush_bubble: v=%b mr=%b cnt=%0d required 0 0 %0d",
                     ex_valid, MemReadIdEx, bubble_cnt, cnt0 + 1);
        else passed++;
        // Stall together with hazard: hold wins, nothing counted.
        load_r2();
        din = rand_slot(); din.v = 1; din.rt = 2; din.rtv = 1;
        ex_stall = 1; cnt0 = mcnt;
        #1;
        checks++;
        if (id_hold !== 1'b1) $display("FAIL stallhaz_hold: hold=%b required 1", id_hold);
        else passed++;
        tick();
        ex_stall = 0;
        checks++;
        if (MemReadIdEx !== 1'b1 || writeRegIdEx !== 3'd2 || bubble_cnt !== 8'(cnt0))
            $display("FAIL stallhaz_keep: mr=%b wr=%0d cnt=%0d required 1 2 %0d",
                     MemReadIdEx, writeRegIdEx, bubble_cnt, cnt0);
        else passed++;
        tick();
        $display("flush_priority: flush and stall precedence checked");
    endtask

    task automatic test_stall_hold();
        slot_t snap;
        din = rand_slot(); din.v = 1; din.mr = 0;
        tick();
        snap = m;
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            din = rand_slot();
            #1;
            checks++;
            if (id_hold !== 1'b1) $display("FAIL stall_hold_%0d: hold=%b required 1", i, id_hold);
            else passed++;
            tick();
            checks++;
            if (obs() !== snap) $display("FAIL stall_keep_%0d: got %h required %h", i, obs(), snap);
            else passed++;
        end
        ex_stall = 0;
        $display("stall_hold: 3 stalled cycles checked");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            din      = rand_slot();
            ex_stall = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (id_hold !== 1'(model_hold())) begin
                $display("FAIL rand_hold_%0d: hold=%b required %b", i, id_hold, model_hold());
                errs++;
            end else passed++;
            tick();
            checks++;
            if (obs() !== m || bubble_cnt !== 8'(mcnt)) begin
                $display("FAIL rand_slot_%0d: got %h cnt=%0d required %h cnt=%0d",
                         i, obs(), bubble_cnt, m, mcnt);
                errs++;
            end else passed++;
        end
        ex_stall = 0; flush = 0;
        $display("random: 400 cycles, %0d mismatching cycles", errs);
    endtask

    task automatic test_saturation();
        din = rand_slot();
        flush = 1;
        for (int i = 0; i < 260; i++) tick();
        flush = 0;
        checks++;
        if (bubble_cnt !== 8'hFF || mcnt != 255)
            $display("FAIL saturation: cnt=%h required ff", bubble_cnt);
        else passed++;
        load_r2();
        din = rand_slot(); din.v = 1; din.rs = 2; din.rsv = 1;
        tick();
        checks++;
        if (bubble_cnt !== 8'hFF || ex_valid !== 1'b0)
            $display("FAIL saturation_hold: cnt=%h v=%b required ff 0", bubble_cnt, ex_valid);
        else passed++;
        $display("saturation: bubble_cnt=%h", bubble_cnt);
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_hazard();
        test_flush_priority();
        test_stall_hold();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register for the 5-stage 16-bit core with 8 architectural registers.
- Captures decoded operands and control from ID and presents them to EX and the forwarding unit: register indices, valid bits, RegWrite, MemRead.
- Detects load-use hazards; on a hazard it holds IF/ID and inserts a one-cycle bubble, because load data can only be forwarded from MEM/WB.
- Honours a downstream stall (hold) and a branch flush (bubble), and counts inserted bubbles.

Parameters:
- DATA_W, 16, operand/immediate/PC width
- REG_W, 3, register index width
- CNT_W, 8, bubble counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_write_reg  in  REG_W each  source/destination indices
- id_rs_valid, id_rt_valid, id_write_reg_valid  in  1 each  index actually used
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- id_alu_op  in  4  ALU operation
- id_rs_data, id_rt_data, id_imm, id_pc  in  DATA_W each  operands, immediate, PC+2
- ex_stall  in  1  EX cannot accept (hold this register)
- flush  in  1  branch/jump resolved taken in EX; squash the ID instruction
- ex_valid  out  1  EX holds a real instruction
- RsIdEx, RtIdEx, writeRegIdEx  out  REG_W each  registered indices
- RsValidIdEx, RtValidIdEx, writeRegValidIdEx  out  1 each
- RegWriteIdEx, MemReadIdEx, MemWriteIdEx  out  1 each
- aluOpIdEx  out  4
- rsDataIdEx, rtDataIdEx, immIdEx, pcIdEx  out  DATA_W each
- id_hold  out  1  IF/ID must not advance this cycle
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset: asynchronous and active-high on rst. All outputs and state reset to 0, including bubble_cnt; id_hold is 0 while in reset.
- Load-use hazard (combinational from current register state and ID inputs): hazard = ex_valid & MemReadIdEx & writeRegValidIdEx & id_valid & ((id_rs_valid & id_rs==writeRegIdEx) | (id_rt_valid & id_rt==writeRegIdEx)).
- id_hold = ~flush & (ex_stall | hazard).
- Per-edge update priority (first match wins):
  1. flush: load a bubble (all valids, RegWrite, MemRead, MemWrite, aluOp, data fields = 0).
  2. ex_stall: hold every register unchanged.
  3. hazard: load a bubble; the ID instruction is retained upstream via id_hold.
  4. Otherwise: capture all id_* inputs; ex_valid <= id_valid.
- Capturing with id_valid=0 also zeroes RegWrite, MemRead and MemWrite, so invalid slots never write.
- Latency: exactly 1 cycle ID->EX when no hold or flush.
- bubble_cnt increments by 1 on each edge where case 1 or case 3 loads a bubble. It saturates at all-ones and does not wrap.
- Simultaneous events:
  - flush with hazard or ex_stall: flush wins, id_hold=0, one bubble counted.
  - ex_stall with hazard: hold wins, no bubble counted, id_hold=1.
- A hazard lasts exactly one cycle: after the bubble, ex_valid=0, so hazard deasserts and the held instruction advances on the next edge.
- Asserting rst mid-stall clears all state immediately; id_hold drops the same cycle.

Test Plan:
- Reset: assert rst with random inputs -> all outputs 0 asynchronously, before any clock edge; bubble_cnt=0.
- Pass-through: id_valid=1, id_rs=3, id_rt=5, id_reg_write=1, id_rs_data=16'h1234 -> one edge later RsIdEx=3, RtIdEx=5, RegWriteIdEx=1, rsDataIdEx=16'h1234, ex_valid=1, id_hold=0.
- Load-use: EX holds a load to r2 (MemReadIdEx=1, writeRegIdEx=2); ID has id_rs=2, id_rs_valid=1 -> id_hold=1.
  - Next edge: ex_valid=0, RegWriteIdEx=0, bubble_cnt=1.
  - Following edge: the dependent instruction is captured with RsIdEx=2.
- No false hazard: same as load-use but id_rs_valid=0, or the load has writeRegValidIdEx=0 -> id_hold=0, no bubble.
- Flush priority: hazard, ex_stall and flush all asserted -> id_hold=0; next edge loads a bubble and bubble_cnt increments once.
- Stall hold and saturation:
  - Assert ex_stall for 3 cycles while id_* inputs change -> outputs unchanged throughout.
  - Force 260 bubbles -> bubble_cnt=8'hFF.
